// File: rtl/eq_cmp_arbiter.sv
// eq_cmp_arbiter: one registered WIDTH-bit equality comparator shared by NREQ requesters.
// Round-robin by default; define EQ_CMP_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module eq_cmp_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] opa,
    input  logic [NREQ*WIDTH-1:0] opb,
    output logic [NREQ-1:0]       gnt,
    output logic                  res_valid,
    output logic                  res_eq,
    output logic [IDW-1:0]        res_id,
    input  logic                  res_ready
);

    typedef enum logic [1:0] {IDLE, CMP, HOLD} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              res_valid_q, res_valid_d;
    logic              res_eq_q, res_eq_d;
    logic [IDW-1:0]    res_id_q, res_id_d;

    logic [IDW-1:0]    win;
    logic [IDW-1:0]    lo_w;
    logic [WIDTH-1:0]  sel_a, sel_b;

`ifndef EQ_CMP_ARBITER_FIXED_PRIO_EN
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    hi_w;
    logic              hi_any;

    // Prefer the lowest request at or above ptr; otherwise wrap to the lowest overall.
    always_comb begin
        lo_w   = '0;
        hi_w   = '0;
        hi_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_w = IDW'(i);
            end
            if (req[i] && (i >= int'(ptr_q))) begin
                hi_w   = IDW'(i);
                hi_any = 1'b1;
            end
        end
        win = hi_any ? hi_w : lo_w;
    end
`else
    always_comb begin
        lo_w = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_w = IDW'(i);
            end
        end
        win = lo_w;
    end
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                sel_a = opa[i*WIDTH +: WIDTH];
                sel_b = opb[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        opa_d       = opa_q;
        opb_d       = opb_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_eq_d    = res_eq_q;
        res_id_d    = res_id_q;
`ifndef EQ_CMP_ARBITER_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = NREQ'(1) << win;
                    opa_d   = sel_a;
                    opb_d   = sel_b;
                    id_d    = win;
                    state_d = CMP;
`ifndef EQ_CMP_ARBITER_FIXED_PRIO_EN
                    ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`endif
                end
            end
            CMP: begin
                res_eq_d    = (opa_q == opb_q);
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_eq_q    <= 1'b0;
            res_id_q    <= '0;
`ifndef EQ_CMP_ARBITER_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_eq_q    <= res_eq_d;
            res_id_q    <= res_id_d;
`ifndef EQ_CMP_ARBITER_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_eq    = res_eq_q;
    assign res_id    = res_id_q;

endmodule

// File: doc/eq_cmp_arbiter.md
Name: eq_cmp_arbiter

Overview:
- Shares one registered WIDTH-bit equality comparator among NREQ requesters.
- Each requester presents an operand pair with a request. The block grants round-robin, evaluates the operands for equality, and returns the result with the winner's ID over a valid/ready handshake.
- Sits between branch-evaluating sequencers and the single shared compare resource.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, operand width in bits.
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request; bit i belongs to requester i.
- opa  input  NREQ*WIDTH  flattened operand A; slice i is [i*WIDTH +: WIDTH].
- opb  input  NREQ*WIDTH  flattened operand B; same slicing as opa.
- gnt  output  NREQ  registered one-hot grant, 1-cycle pulse.
- res_valid  output  1  result available.
- res_eq  output  1  1 when the granted opa slice equals the opb slice bitwise.
- res_id  output  IDW  index of the requester that owns the result.
- res_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (asynchronous, any time):
  - gnt=0, res_valid=0, res_eq=0, res_id=0.
  - Round-robin pointer ptr=0, state=IDLE, operand registers=0.
  - An in-flight operation is discarded; no result is emitted after reset.
- FSM states: IDLE, CMP, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the winner w: the first set req bit searching from ptr upward, wrapping NREQ-1 -> 0.
  - At the edge: gnt <= one-hot(w); capture opa/opb slice w into internal registers; id_r <= w; ptr <= (w==NREQ-1) ? 0 : w+1; go to CMP.
- CMP:
  - At the edge: gnt <= 0; res_eq <= (opa_r == opb_r); res_id <= id_r; res_valid <= 1; go to HOLD.
- HOLD:
  - res_valid, res_eq and res_id hold stable until res_valid && res_ready is seen at an edge.
  - At that edge: res_valid <= 0; go to IDLE. res_eq and res_id keep their last values.
  - req is ignored in CMP and HOLD.
- Latency:
  - Request sampled at edge k -> gnt high during cycle k..k+1.
  - res_valid high from edge k+1.
  - Minimum issue interval is 3 cycles with res_ready tied high.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Deassert req in the cycle gnt is high; the earliest re-arbitration is 2 edges later.
- Comparison is bitwise equality over all WIDTH bits; signedness is irrelevant. No X-propagation handling is required.
- Simultaneous events:
  - A req that rises in the same cycle res_ready completes the handshake is arbitrated on the next IDLE edge, not the same edge.
  - Only one grant is ever outstanding.
- If res_ready is held low indefinitely, the block stalls in HOLD; requests stay pending and ungranted.
- Wrap-around: ptr returns to 0 after granting requester NREQ-1.

Optional Feature:
- Macro: EQ_CMP_ARBITER_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority; the lowest set req index always wins.
  - ptr is removed; no pointer update.
- Undefined: round-robin arbitration as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- Reset then single request: req=4'b0001, opa[0]=1, opb[0]=1, res_ready=1.
  - gnt=0001 one cycle later.
  - Next cycle: res_valid=1, res_eq=1, res_id=0.
  - Then res_valid=0.
- Mismatch: requester 2 with opa=0, opb=2.
  - res_eq=0, res_id=2.
  - Then requester 2 with opa=1, opb=3 -> res_eq=0.
  - Then opa=5, opb=5 -> res_eq=1.
- Round-robin fairness: req=4'b1111 held continuously, each requester dropping req on its gnt and re-raising it after.
  - Grant order 0,1,2,3,0.
  - With FIXED_PRIO_EN defined, the order is 0,0,0.
- Backpressure: res_ready=0 for 5 cycles after res_valid with req[1]=1 pending.
  - res_valid, res_eq and res_id stay stable; no gnt issued.
  - Raise res_ready -> res_valid drops -> gnt=0010 on the following edge.
- Reset mid-operation: assert rst_n=0 asynchronously while in CMP (after gnt=0100).
  - All outputs are 0 immediately.
  - After release, no res_valid appears without a new request; ptr=0, so req=1111 grants 0 first.
- Wrap-around and 32-bit boundary: requester 3 with opa=32'hFFFFFFFF, opb=32'hFFFFFFFE.
  - res_eq=0, res_id=3.
  - Next req=1001 grants 0 (ptr wrapped).
